// File: rtl/video_pkg.sv
// Shared video types for the ADV7511 output path.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead pixel FIFO with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pix_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Pointer next-state; a flush drops everything stored so far but keeps a same-cycle write.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/video_ddr_packer.sv
// Pixel-rate to DDR half-word packer: phase counter, pixel clock,
// raster timing capture, FIFO pop and DDR output mux.
module video_ddr_packer
    import video_pkg::*;
#(
    parameter int unsigned PIX_W      = 24,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic        HS_POL     = 1'b1,
    parameter logic        VS_POL     = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [PIX_W-1:0]              i_data,
    output logic                          o_ready,
    output logic                          o_pix_ce,
    input  logic                          i_de,
    input  logic                          i_hsync,
    input  logic                          i_vsync,
    output logic                          o_clk_pixel,
    output logic                          o_de,
    output logic                          o_hsync,
    output logic                          o_vsync,
    output logic [PIX_W/2-1:0]            o_data,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned       PW      = $clog2(CLK_DIV);
    localparam int unsigned       HALF    = PIX_W / 2;
    localparam logic [PW-1:0]     PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]     PH_HALF = PW'(CLK_DIV / 2);

    logic [PW-1:0]    ph_q, ph_d;
    logic             clk_pix_q, clk_pix_d;
    timing_t          tim_q, tim_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic             uf_q, uf_d;

    logic             fifo_full, fifo_empty, vs_rise;
    logic [PIX_W-1:0] fifo_rd_data;

    assign o_pix_ce = (ph_q == PH_LAST);
    assign vs_rise  = o_pix_ce && i_vsync && !tim_q.vs;

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (vs_rise),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .rd_en   (o_pix_ce && i_de),
        .rd_data (fifo_rd_data),
        .level   (o_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_ready = !fifo_full;

    // Next-state: phase wrap, pixel clock from the upcoming phase, pixel-sample actions.
    always_comb begin
        ph_d      = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        clk_pix_d = (ph_d < PH_HALF);
        tim_d     = tim_q;
        hold_d    = hold_q;
        uf_d      = uf_q;
        if (o_pix_ce) begin
            tim_d  = '{de: i_de, hs: i_hsync, vs: i_vsync};
            hold_d = (i_de && !fifo_empty) ? fifo_rd_data : '0;
            if (i_de && fifo_empty) begin
                uf_d = 1'b1;
            end
            // Frame resync clear takes priority over a same-sample underflow.
            if (vs_rise) begin
                uf_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q      <= '0;
            clk_pix_q <= 1'b1;
            tim_q     <= TIMING_IDLE;
            hold_q    <= '0;
            uf_q      <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            clk_pix_q <= clk_pix_d;
            tim_q     <= tim_d;
            hold_q    <= hold_d;
            uf_q      <= uf_d;
        end
    end

    assign o_clk_pixel = clk_pix_q;
    assign o_de        = tim_q.de;
    assign o_hsync     = HS_POL ? tim_q.hs : ~tim_q.hs;
    assign o_vsync     = VS_POL ? tim_q.vs : ~tim_q.vs;
    assign o_underflow = uf_q;
    assign o_data      = !tim_q.de ? '0 :
                         clk_pix_q ? hold_q[PIX_W-1:HALF] : hold_q[HALF-1:0];

endmodule

// File: doc/video_ddr_packer.md
# video_ddr_packer

Parametrised pixel-rate to DDR-bus packer for the ADV7511 output path. It accepts a pixel stream from the upsampler through an internal FIFO with a valid/ready handshake. It takes raster timing (de/hsync/vsync) from the HD signal generator and paces that generator with a pixel-clock strobe. It emits a half-width data word per clock half-period together with a derived pixel clock, so the pixel clock is no longer produced by a separate module.

## Interface
- PIX_W, 24, pixel width in bits; even; output half-word is PIX_W/2.
- CLK_DIV, 4, `clk` cycles per pixel; even, ≥2.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, ≥2.
- HS_POL, 1'b1, active level of `o_hsync`; output inverted when 0.
- VS_POL, 1'b1, active level of `o_vsync`; output inverted when 0.

Ports:
- clk  in  1  single clock for the whole block (CLK_DIV × pixel rate).
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  pixel write request.
- i_data  in  PIX_W  pixel, {R,G,B} MSB first.
- o_ready  out  1  FIFO not full.
- o_pix_ce  out  1  one-cycle strobe; the timing generator advances one pixel on it.
- i_de  in  1  active-video flag from the generator; sampled on `o_pix_ce`.
- i_hsync  in  1  active-high hsync from the generator; sampled on `o_pix_ce`.
- i_vsync  in  1  active-high vsync from the generator; sampled on `o_pix_ce`.
- o_clk_pixel  out  1  pixel clock, 50 % duty.
- o_de  out  1  registered data enable.
- o_hsync  out  1  registered hsync, polarity per HS_POL.
- o_vsync  out  1  registered vsync, polarity per VS_POL.
- o_data  out  PIX_W/2  DDR half-word.
- o_underflow  out  1  sticky: pixel demanded while FIFO empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Phase counter `ph` runs 0..CLK_DIV-1 and wraps.
- `o_pix_ce` = (`ph` == CLK_DIV-1).
- `o_clk_pixel` = 1 for `ph` < CLK_DIV/2, otherwise 0. It is registered, so it has no glitches.
- FIFO write: occurs when `i_valid` && `o_ready`. `o_ready` = `o_level` < FIFO_DEPTH.
- Pixel sample on `o_pix_ce`:
  - Capture `i_de`, `i_hsync` and `i_vsync`.
  - If `i_de` is set and the FIFO is non-empty, pop one pixel into the output holding register.
  - If `i_de` is set and the FIFO is empty, load 0 into the holding register and set `o_underflow`.
  - If `i_de` is clear, load 0 into the holding register and do not pop.
- A simultaneous write and pop is allowed in any state. The level is unchanged, and a write into an empty FIFO is not poppable in the same cycle.
- Frame resync:
  - Trigger: the sampled `i_vsync` rises (0→1 between consecutive `o_pix_ce` samples).
  - The FIFO is flushed (level becomes 0) and `o_underflow` clears.
  - A write in the same cycle as the flush is kept, so level becomes 1.
- DDR output:
  - For `ph` < CLK_DIV/2, `o_data` = holding register [PIX_W-1:PIX_W/2].
  - Otherwise `o_data` = holding register [PIX_W/2-1:0].
  - `o_data` is 0 whenever `o_de` = 0.
- Reset clears:
  - `ph` = 0; the FIFO is emptied.
  - `o_ready` = 1, `o_level` = 0, `o_pix_ce` = 0.
  - `o_clk_pixel` = 1, `o_de` = 0, `o_hsync` = ~HS_POL, `o_vsync` = ~VS_POL.
  - `o_data` = 0, `o_underflow` = 0.
- Reset asserted mid-frame discards all state. The first `o_pix_ce` comes CLK_DIV cycles after reset deasserts.

## Timing
- Inputs `i_de`, `i_hsync` and `i_vsync` sampled at cycle t (`ph` = CLK_DIV-1) appear on `o_de`/`o_hsync`/`o_vsync` at t+1 (`ph` = 0). They hold for CLK_DIV cycles.
- The high half-word is valid at t+1..t+CLK_DIV/2 and the low half-word at the remaining cycles, aligned to the `o_clk_pixel` high and low phases.
- Pixel latency from FIFO head to `o_data` is 1 cycle after the sampling `o_pix_ce`.
- `o_level` and `o_ready` update 1 cycle after the write/pop/flush.
- `o_underflow` sets at t+1 and clears at t+1 of the sampled vsync rise. If underflow and a vsync rise occur on the same sample, the clear wins.

## Structure
- Shared package `video_pkg`: `rgb_t` (struct of three bytes) and `timing_t` (`de`, `hs`, `vs`).
- Sub-module `pix_fifo`:
  - Synchronous FIFO, parametrised by width and depth, with synchronous flush.
  - Uses pointers one bit wider than the address for full/empty detection.
  - Outputs level, full and empty.
- The top level holds the phase counter, timing capture and DDR mux.

## Test plan
- Reset, then CLK_DIV=4 idle: `o_pix_ce` pulses every 4 cycles, the first at cycle 4 after reset deassert. `o_clk_pixel` reads 1,1,0,0 across each pixel. `o_hsync`=0, `o_vsync`=0.
- Write 0xA5B6C7, then present `i_de`=1: `o_data` = 0xA5B for 2 cycles, then 0x6C7 for 2 cycles, and `o_de`=1 for 4 cycles.
- Fill 16 pixels without pops: `o_ready`=0 and `o_level`=16; a 17th `i_valid` is dropped. After one pop, `o_level`=15 and `o_ready`=1.
- Present `i_de`=1 with the FIFO empty: `o_data`=0 and `o_underflow`=1. Then a sampled `i_vsync` rise clears it and flushes the FIFO from level 5 to 0.
- Drive a simultaneous write and pop at level 3: `o_level` stays 3, and the data order is preserved across 20 random pixels.
- Set HS_POL=0, VS_POL=0: `o_hsync`/`o_vsync` are 1 at reset and read inverted relative to `i_hsync`/`i_vsync`. Assert reset mid-line: all outputs return to reset values on the next cycle.
